cpu6_bus_interface: RTL and testbench

Memory bus interface unit directly downstream of the CPU6 datapath.
- Owns the 16-bit memory address register, loaded byte-wise from the F bus.
- Runs single read/write cycles against external memory with a ready/wait handshake.
- Returns read bytes for the internal D bus.
- Asserts busy so the microsequencer can stall on its condition input.

---
 rtl/cpu6_bus_interface.sv | 146 ++++++++++++++
 tb/tb_cpu6_bus_interface.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_bus_interface.sv
// CPU6 memory bus interface: 16-bit address register plus a single-access read/write
// sequencer (IDLE/SETUP/ACCESS/DONE). Define BUS_TIMEOUT_EN to add the ACCESS watchdog.
module cpu6_bus_interface #(
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  fbus,
  input  logic        ld_addr_hi,
  input  logic        ld_addr_lo,
  input  logic        inc_addr,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam bit NO_SETUP = (SETUP_CYCLES == 0);
  localparam int SCW      = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  state_t         state;
  logic           is_read;
  logic [SCW-1:0] setup_cnt;
  logic [15:0]    addr;
  logic           accept;

  assign mem_addr = addr;
  assign accept   = ((state == IDLE) || (state == DONE)) && (rd_req || wr_req);

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`else
  // No watchdog: the error flag is a constant 0 for any legal TIMEOUT.
  assign bus_err = (TIMEOUT < 0);
`endif

  // Address register is frozen while a cycle is in flight; a load beats an increment.
  // NOTE: clocked blocks use non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr <= 16'h0000;
    end else if (!busy) begin
      if (ld_addr_hi || ld_addr_lo) begin
        if (ld_addr_hi) addr[15:8] <= fbus;
        if (ld_addr_lo) addr[7:0]  <= fbus;
      end else if (inc_addr) begin
        addr <= addr + 16'd1;
      end
    end
  end

  // Sequencer; busy and the strobes are registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      is_read   <= 1'b0;
      setup_cnt <= '0;
      busy      <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      mem_wdata <= 8'h00;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt    <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Read wins when both requests arrive together.
            is_read <= rd_req;
            if (!rd_req) mem_wdata <= fbus;
            busy    <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            bus_err <= 1'b0;
            to_cnt  <= '0;
`endif
            if (NO_SETUP) begin
              state  <= ACCESS;
              mem_rd <= rd_req;
              mem_wr <= !rd_req;
            end else begin
              state     <= SETUP;
              setup_cnt <= SCW'(SETUP_CYCLES - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (setup_cnt == '0) begin
            state  <= ACCESS;
            mem_rd <= is_read;
            mem_wr <= !is_read;
          end else begin
            setup_cnt <= setup_cnt - SCW'(1);
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state  <= DONE;
            busy   <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (is_read) begin
              rd_data  <= mem_rdata;
              rd_valid <= 1'b1;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            bus_err <= 1'b1;
            if (is_read) begin
              rd_data  <= 8'hFF;
              rd_valid <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_bus_interface.sv
// Directed bench for cpu6_bus_interface; read bytes are checked by a scoreboard monitor on rd_valid.
module tb_cpu6_bus_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  fbus;
  logic        ld_addr_hi, ld_addr_lo, inc_addr, rd_req, wr_req;
  logic        busy, rd_valid, bus_err, mem_rd, mem_wr, mem_ready;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_byte;

  cpu6_bus_interface dut (
    .clock(clock), .reset(reset), .fbus(fbus),
    .ld_addr_hi(ld_addr_hi), .ld_addr_lo(ld_addr_lo), .inc_addr(inc_addr),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .bus_err(bus_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected byte.
  always @(negedge clock) begin
    if (reset && rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unexpected: got pulse with rd_data %0h expected none", rd_data);
      end else begin
        exp_byte = sb.pop_front();
        check("rd_data_sb", rd_data, exp_byte);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "time limit");
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic load_addr(input logic [15:0] a);
    ld_addr_hi = 1'b1; fbus = a[15:8]; step();
    ld_addr_hi = 1'b0; ld_addr_lo = 1'b1; fbus = a[7:0]; step();
    ld_addr_lo = 1'b0;
  endtask

  initial begin
    int busy_cnt, wr_cycles, guard, rd_cycles;
    reset = 1'b0; fbus = 8'h00; ld_addr_hi = 0; ld_addr_lo = 0; inc_addr = 0;
    rd_req = 0; wr_req = 0; mem_rdata = 8'h00; mem_ready = 1'b0;
    #1;
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_ctrl", {busy, rd_valid, mem_rd, mem_wr, bus_err}, 5'b0);
    step(); step();
    #4 reset = 1'b1;

    // Address register: byte loads, increment, wrap, load-beats-inc.
    load_addr(16'h1234);
    ld_addr_hi = 1'b1; fbus = 8'h12; step(); ld_addr_hi = 1'b0;
    ld_addr_lo = 1'b1; fbus = 8'h34; step(); ld_addr_lo = 1'b0;
    inc_addr = 1'b1; step(); inc_addr = 1'b0;
    check("addr_inc", mem_addr, 16'h1235);
    ld_addr_hi = 1'b1; ld_addr_lo = 1'b1; fbus = 8'hFF; step();
    ld_addr_hi = 1'b0; ld_addr_lo = 1'b0;
    check("addr_both", mem_addr, 16'hFFFF);
    inc_addr = 1'b1; step(); inc_addr = 1'b0;
    check("addr_wrap", mem_addr, 16'h0000);
    ld_addr_lo = 1'b1; inc_addr = 1'b1; fbus = 8'h80; step();
    ld_addr_lo = 1'b0; inc_addr = 1'b0;
    check("addr_ld_over_inc", mem_addr, 16'h0080);

    // Zero-wait read.
    load_addr(16'h1234);
    mem_rdata = 8'hA5; mem_ready = 1'b1; rd_req = 1'b1; sb.push_back(8'hA5);
    step(); rd_req = 1'b0;
    check("rd_setup", {busy, mem_rd}, 2'b10);
    check("rd_addr", mem_addr, 16'h1234);
    busy_cnt = int'(busy);
    step();
    check("rd_access", {busy, mem_rd}, 2'b11);
    busy_cnt += int'(busy);
    step();
    check("rd_done", {busy, mem_rd, rd_valid}, 3'b001);
    check("rd_busy_cycles", busy_cnt, 2);

    // Write with three wait states; address load during busy is dropped.
    wr_req = 1'b1; fbus = 8'h5A; mem_ready = 1'b0; step();
    wr_req = 1'b0; ld_addr_hi = 1'b1; fbus = 8'h77;
    check("wr_setup", {busy, mem_wr}, 2'b10);
    wr_cycles = 0; guard = 0;
    while (busy && guard < 20) begin
      step(); guard++;
      if (guard == 2) ld_addr_hi = 1'b0;
      if (mem_wr) begin
        wr_cycles++;
        check("wr_wdata", mem_wdata, 8'h5A);
        if (wr_cycles == 4) mem_ready = 1'b1;
      end
    end
    check("wr_idle", busy, 1'b0);
    check("wr_strobe_cycles", wr_cycles, 4);
    check("wr_addr_held", mem_addr, 16'h1234);

    // Read+write together (read wins), then back-to-back read from DONE.
    mem_rdata = 8'h3C; fbus = 8'h99; rd_req = 1'b1; wr_req = 1'b1; sb.push_back(8'h3C);
    step(); rd_req = 1'b0; wr_req = 1'b0;
    check("rw_wdata_kept", mem_wdata, 8'h5A);
    step();
    check("rw_is_read", {mem_rd, mem_wr}, 2'b10);
    step();
    check("rw_done", {busy, rd_valid}, 2'b01);
    rd_req = 1'b1; mem_rdata = 8'hC3; sb.push_back(8'hC3);
    step(); rd_req = 1'b0;
    check("b2b_direct_setup", {busy, mem_rd}, 2'b10);
    wait_idle("b2b_idle", 10);

    // Reset in the middle of ACCESS.
    mem_ready = 1'b0; rd_req = 1'b1; step(); rd_req = 1'b0;
    step();
    check("mid_access", mem_rd, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst", {busy, mem_rd, rd_valid}, 3'b000);
    check("async_rst_addr", mem_addr, 16'h0000);
    step();
    #3 reset = 1'b1;
    mem_rdata = 8'hE7; mem_ready = 1'b1; rd_req = 1'b1; sb.push_back(8'hE7);
    step(); rd_req = 1'b0;
    wait_idle("post_rst_read", 10);
    check("post_rst_rd_data", rd_data, 8'hE7);

    // Memory never ready.
    mem_ready = 1'b0; rd_req = 1'b1;
`ifdef BUS_TIMEOUT_EN
    sb.push_back(8'hFF);
`endif
    step(); rd_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
    rd_cycles = 0; guard = 0;
    while (busy && guard < 100) begin
      step(); guard++;
      if (mem_rd) rd_cycles++;
    end
    check("to_idle", busy, 1'b0);
    check("to_access_cycles", rd_cycles, 15);
    check("to_bus_err", bus_err, 1'b1);
    check("to_rd_data", rd_data, 8'hFF);
    mem_ready = 1'b1; wr_req = 1'b1; fbus = 8'h11; step(); wr_req = 1'b0;
    check("to_err_cleared", bus_err, 1'b0);
    wait_idle("to_next_write", 10);
`else
    busy_cnt = 0; rd_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      busy_cnt += int'(busy);
    end
    check("hang_busy_cycles", busy_cnt, 100);
    check("hang_no_err", bus_err, 1'b0);
    #2 reset = 1'b0;
    step();
    #3 reset = 1'b1;
`endif

    step(); step();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
